vend_payout_ctrl: RTL and testbench
===================================

# vend_payout_ctrl

Payout controller at the output side of the vending machine FSM. It captures each dispense event the FSM emits on `out` and `change[1:0]`, queues the events in a small FIFO and plays them out to the physical actuators. Each event drives a fixed-width bottle-release pulse, then pays change as 5 rs coins from a single hopper using a drive/ack handshake. It sits between `vending_machine_18105070` and the mechanism drivers.

## Interface
- `DEPTH`, 4: event FIFO entries (power of two, ≥2)
- `PULSE_CYC`, 4: bottle-release pulse width in clk cycles (≥1)
- `TIMEOUT`, 16: max cycles `coin_drv` may wait for `coin_ack` before a jam is declared (≥2)

Ports:
- `clk` in 1: system clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `out` in 1: bottle-dispense indication from the vending FSM
- `change` in 2: change code from the vending FSM; 00 none, 01 5 rs, 10 10 rs, 11 illegal
- `coin_ack` in 1: hopper sensor, high for ≥1 cycle when one 5 rs coin has left
- `jam_clr` in 1: one-cycle pulse, service clears jam
- `bottle_drv` out 1: bottle release solenoid
- `coin_drv` out 1: hopper motor enable
- `busy` out 1: FSM not in IDLE, or FIFO not empty
- `jam` out 1: hopper jam detected (sticky)
- `ovf` out 1: event dropped because FIFO full (sticky until reset)
- `err` out 1: illegal change code 11 captured (sticky until reset)

## Operation
- Capture: at each rising edge where `out`=1 or `change`≠00, push {out, change} into the FIFO. Every edge with the condition true is a separate event.
- Full FIFO with a push and no pop in the same edge: drop the event and set `ovf`. Full with a simultaneous pop: accept the push.
- Coin count per event: 00→0, 01→1, 10→2. For 11, count is 0, set `err`, and still honor the bottle bit.
- FSM states: IDLE, BOTTLE, COIN, GAP, JAM.
  - IDLE: if the FIFO is non-empty, pop and load `coins_left`. Go to BOTTLE if bit out=1, else COIN if coins_left>0, else stay in IDLE. An empty event still consumes a pop.
  - BOTTLE: `bottle_drv`=1 for exactly PULSE_CYC cycles, then go to COIN if coins_left>0, else IDLE.
  - COIN: `coin_drv`=1. When `coin_ack` is sampled 1, decrement `coins_left` and go to GAP if the result is >0, else IDLE. A wait counter runs from entry to COIN.
  - GAP: one cycle with `coin_drv`=0, so the hopper sees distinct pulses. Then go to COIN, with the wait counter reset.
  - JAM: all drivers 0, `jam`=1, FIFO keeps accepting events. When `jam_clr` is sampled 1, go to COIN and retry the same coin (`coins_left` unchanged).
- `coin_ack` outside COIN is ignored.
- `busy` = (state≠IDLE) | FIFO non-empty.

## Timing
- Reset (`rst`=0, async): state IDLE, FIFO empty, counters 0. `bottle_drv`, `coin_drv`, `busy`, `jam`, `ovf`, `err` all 0. Reset mid-payout aborts immediately: drivers drop without waiting for a clock, and queued events are lost.
- Event sampled at edge E → popped at edge E+1 if the FSM is idle. `bottle_drv` is high from E+1 to E+1+PULSE_CYC. COIN is then entered, so `coin_drv` rises at E+1+PULSE_CYC.
- Change-only event: `coin_drv` rises at edge E+1.
- Ack at edge A: `coin_drv` low after A. For a second coin, `coin_drv` is high again after A+1.
- Jam: wait counter reaches TIMEOUT with no ack → JAM entered at that edge, `coin_drv` drops, `jam` rises the same edge.
- Outputs are all registered. No combinational path from input to output.

## Configuration
- `PAYOUT_JAM_DETECT_EN` defined: wait counter, JAM state and `jam_clr` handling are compiled in, as described above.
- Not defined: no timeout logic; COIN waits indefinitely for `coin_ack`; `jam` is tied 0; `jam_clr` is ignored.

## Test plan
- Reset release, then `out`=1 and `change`=10 for one cycle at edge E → `bottle_drv` high for 4 cycles from E+1. Then `coin_drv` pulses twice, ack at cycles 3 and 2 of each pulse with one GAP low cycle between. `busy` falls after the second ack.
- `change`=01, `out`=0 → no bottle pulse, single `coin_drv` pulse starting at E+1, ends on ack.
- 6 back-to-back events while the hopper never acks (JAM_DETECT off) → 4 queued plus 1 popped, then `ovf`=1; remaining events execute in order once acks resume.
- JAM_DETECT on, no `coin_ack` → `jam`=1 exactly 16 cycles after COIN entry, `coin_drv`=0. `jam_clr` pulse → `coin_drv` reasserts, ack completes, `jam` cleared.
- `change`=11 with `out`=1 → `err`=1, bottle pulse of 4 cycles, zero coin pulses.
- `rst` asserted mid-COIN with 2 events queued → all outputs 0 immediately, FIFO empty, no payout after release.

Source files
------------

// File: rtl/vend_payout_ctrl_if.sv
// Signal bundle between the vending FSM, the mechanism drivers and vend_payout_ctrl.
interface vend_payout_ctrl_if;
    logic       out;
    logic [1:0] change;
    logic       coin_ack;
    logic       jam_clr;
    logic       bottle_drv;
    logic       coin_drv;
    logic       busy;
    logic       jam;
    logic       ovf;
    logic       err;
    logic [2:0] state_dbg;

    // coin_drv/coin_ack: coin_drv is held high until coin_ack is sampled high on a
    // rising edge; that edge completes exactly one coin and coin_drv drops after it.
    modport master (
        output out, change, coin_ack, jam_clr,
        input  bottle_drv, coin_drv, busy, jam, ovf, err, state_dbg
    );
    modport slave (
        input  out, change, coin_ack, jam_clr,
        output bottle_drv, coin_drv, busy, jam, ovf, err, state_dbg
    );
endinterface

// File: rtl/vend_payout_ctrl.sv
// Queues vending dispense events and plays them out as a bottle pulse plus 5 rs coins.
// Optional macro PAYOUT_JAM_DETECT_EN adds hopper timeout, JAM state and jam_clr recovery.
module vend_payout_ctrl #(
    parameter int DEPTH     = 4,
    parameter int PULSE_CYC = 4,
    parameter int TIMEOUT   = 16
) (
    input logic               clk,
    input logic               rst,
    vend_payout_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(PULSE_CYC + 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYC - 1);
    localparam logic [AW:0]   FULL       = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BOTTLE = 3'd1,
        COIN   = 3'd2,
        GAP    = 3'd3,
        JAM    = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_n;
    logic          push_req, push, pop;
    logic [2:0]    head;
    logic [1:0]    coins_left, coins_n;
    logic [PW-1:0] pulse_cnt;
    logic          bottle_q, coin_q, busy_q, ovf_q, err_q;

    function automatic logic [1:0] coin_count(input logic [1:0] ch);
        return (ch == 2'b11) ? 2'b00 : ch;
    endfunction

    assign push_req = bus.out | (bus.change != 2'b00);
    assign pop      = (state == IDLE) && (count != '0);
    // A full FIFO still accepts when the FSM frees a slot on the same edge.
    assign push     = push_req && ((count != FULL) || pop);
    assign head     = mem[rd_ptr];
    assign count_n  = count + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            count <= count_n;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_req && !push) ovf_q <= 1'b1;
            if (push_req && (bus.change == 2'b11)) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.out, bus.change};
    end

`ifdef PAYOUT_JAM_DETECT_EN
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    logic [WW-1:0] wait_cnt;
    logic          jam_q;
`endif

    always_comb begin
        state_n = state;
        coins_n = coins_left;
        case (state)
            IDLE: begin
                if (pop) begin
                    coins_n = coin_count(head[1:0]);
                    if (head[2]) state_n = BOTTLE;
                    else if (coin_count(head[1:0]) != 2'd0) state_n = COIN;
                end
            end
            BOTTLE: begin
                if (pulse_cnt == PULSE_LAST) state_n = (coins_left != 2'd0) ? COIN : IDLE;
            end
            COIN: begin
                if (bus.coin_ack) begin
                    coins_n = coins_left - 2'd1;
                    state_n = (coins_left > 2'd1) ? GAP : IDLE;
                end
`ifdef PAYOUT_JAM_DETECT_EN
                else if (wait_cnt == WAIT_LAST) begin
                    state_n = JAM;
                end
`endif
            end
            GAP: state_n = COIN;
`ifdef PAYOUT_JAM_DETECT_EN
            JAM: begin
                if (bus.jam_clr) state_n = COIN;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // Drivers are computed from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            coins_left <= '0;
            pulse_cnt  <= '0;
            bottle_q   <= 1'b0;
            coin_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_n;
            coins_left <= coins_n;
            pulse_cnt  <= (state == BOTTLE && state_n == BOTTLE) ? pulse_cnt + 1'b1 : '0;
            bottle_q   <= (state_n == BOTTLE);
            coin_q     <= (state_n == COIN);
            busy_q     <= (state_n != IDLE) || (count_n != '0);
        end
    end

`ifdef PAYOUT_JAM_DETECT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
            jam_q    <= 1'b0;
        end else begin
            wait_cnt <= (state == COIN && state_n == COIN) ? wait_cnt + 1'b1 : '0;
            jam_q    <= (state_n == JAM);
        end
    end
    assign bus.jam = jam_q;
`else
    logic unused_jam_clr;
    assign unused_jam_clr = bus.jam_clr;
    assign bus.jam = 1'b0;
`endif

    assign bus.bottle_drv = bottle_q;
    assign bus.coin_drv   = coin_q;
    assign bus.busy       = busy_q;
    assign bus.ovf        = ovf_q;
    assign bus.err        = err_q;
    assign bus.state_dbg  = state;
endmodule

// File: tb/tb_vend_payout_ctrl.sv
// Bench for vend_payout_ctrl: directed events, hopper model, pulse scoreboard.
`timescale 1ns/1ps
module tb_vend_payout_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    logic [25:0] exp_q[$];
    int          ack_plan[$];
    int          ack_delay = 2;
    bit          hold = 1'b0;
    int          hi_cnt = 0;
    int          cur_delay = 0;

    bit          on [3];
    int          st [3];
    int          ln [3];
    logic [2:0]  mon_s;
    logic [2:0]  t3_ev [6] = '{3'b001, 3'b100, 3'b010, 3'b101, 3'b001, 3'b110};
    logic [2:0]  t6_ev [3] = '{3'b001, 3'b100, 3'b010};
    int          e;

    vend_payout_ctrl_if bus();

    vend_payout_ctrl #(.DEPTH(4), .PULSE_CYC(4), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // hopper model: acks once coin_drv has been high for cur_delay cycles, unless held
    initial begin
        bus.coin_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.coin_drv === 1'b1) begin
                hi_cnt++;
                if (hi_cnt == 1) begin
                    if (ack_plan.size() != 0) cur_delay = ack_plan.pop_front();
                    else cur_delay = ack_delay;
                end
                bus.coin_ack = !hold && (hi_cnt >= cur_delay);
            end else begin
                hi_cnt = 0;
                bus.coin_ack = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, want, cyc);
    endtask

    function automatic void expect_pulse(input int k, input int start, input int len);
        exp_q.push_back({2'(k), 16'(start), 8'(len)});
    endfunction

    task automatic report(input int k, input int start, input int len);
        logic [25:0] got;
        logic [25:0] want;
        got = {2'(k), 16'(start), 8'(len)};
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL pulse: got kind=%0d start=%0d len=%0d, required no pulse", k, start, len);
        end else begin
            want = exp_q.pop_front();
            if (got == want) n_pass++;
            else $display("FAIL pulse: got kind=%0d start=%0d len=%0d, required kind=%0d start=%0d len=%0d",
                          k, start, len, want[25:24], want[23:8], want[7:0]);
        end
    endtask

    // monitor: kind 1 bottle_drv, 2 coin_drv, 3 jam; each finished pulse is scored
    initial begin
        forever begin
            @(negedge clk);
            mon_s = {bus.jam, bus.coin_drv, bus.bottle_drv};
            for (int k = 0; k < 3; k++) begin
                if (mon_s[k] === 1'b1) begin
                    if (!on[k]) begin
                        on[k] = 1'b1;
                        st[k] = cyc;
                        ln[k] = 0;
                    end
                    ln[k]++;
                end else if (on[k]) begin
                    on[k] = 1'b0;
                    report(k + 1, st[k], ln[k]);
                end
            end
        end
    end

    task automatic goto(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drive(input logic o, input logic [1:0] ch);
        bus.out = o;
        bus.change = ch;
        @(negedge clk);
        bus.out = 1'b0;
        bus.change = 2'b00;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bottle"}, bus.bottle_drv, 0);
        check({tag, "_coin"}, bus.coin_drv, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_jam"}, bus.jam, 0);
        check({tag, "_ovf"}, bus.ovf, 0);
        check({tag, "_err"}, bus.err, 0);
        check({tag, "_state"}, bus.state_dbg, 0);
    endtask

    initial begin
        bus.out = 1'b0;
        bus.change = 2'b00;
        bus.jam_clr = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // bottle + 10 rs change, acks after 3 then 2 cycles
        e = cyc + 1;
        ack_plan.push_back(3);
        ack_plan.push_back(2);
        expect_pulse(1, e + 1, 4);
        expect_pulse(2, e + 5, 3);
        expect_pulse(2, e + 9, 2);
        drive(1'b1, 2'b10);
        check("t1_busy_capture", bus.busy, 1);
        goto(e + 10);
        check("t1_busy_last_coin", bus.busy, 1);
        goto(e + 11);
        check("t1_busy_done", bus.busy, 0);
        goto(e + 14);

        // change-only 5 rs
        e = cyc + 1;
        ack_plan.push_back(2);
        expect_pulse(2, e + 1, 2);
        drive(1'b0, 2'b01);
        goto(e + 2);
        check("t2_busy_coin", bus.busy, 1);
        goto(e + 3);
        check("t2_busy_done", bus.busy, 0);
        goto(e + 6);

        // illegal change code: bottle only, err sticky
        e = cyc + 1;
        check("t5_err_before", bus.err, 0);
        expect_pulse(1, e + 1, 4);
        drive(1'b1, 2'b11);
        check("t5_err_set", bus.err, 1);
        goto(e + 4);
        check("t5_busy_bottle", bus.busy, 1);
        goto(e + 5);
        check("t5_busy_done", bus.busy, 0);
        check("t5_coin_none", bus.coin_drv, 0);
        goto(e + 8);

`ifndef PAYOUT_JAM_DETECT_EN
        // overflow: hopper stalls, 6 back-to-back events, last one dropped
        hold = 1'b1;
        e = cyc + 1;
        expect_pulse(2, e + 1, 11);
        expect_pulse(1, e + 13, 4);
        expect_pulse(2, e + 18, 2);
        expect_pulse(2, e + 21, 2);
        expect_pulse(1, e + 24, 4);
        expect_pulse(2, e + 28, 2);
        expect_pulse(2, e + 31, 2);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) check("t3_ovf_before_drop", bus.ovf, 0);
            bus.out = t3_ev[i][2];
            bus.change = t3_ev[i][1:0];
            @(negedge clk);
        end
        bus.out = 1'b0;
        bus.change = 2'b00;
        check("t3_ovf_after_drop", bus.ovf, 1);
        goto(e + 10);
        hold = 1'b0;
        goto(e + 32);
        check("t3_busy_last", bus.busy, 1);
        goto(e + 33);
        check("t3_busy_done", bus.busy, 0);
        check("t3_ovf_sticky", bus.ovf, 1);
        goto(e + 36);
`else
        // jam: no ack for 16 cycles, then service clear and retry
        hold = 1'b1;
        e = cyc + 1;
        expect_pulse(2, e + 1, 16);
        expect_pulse(3, e + 17, 4);
        expect_pulse(2, e + 21, 2);
        drive(1'b0, 2'b01);
        goto(e + 16);
        check("t4_jam_before", bus.jam, 0);
        check("t4_coin_before", bus.coin_drv, 1);
        goto(e + 17);
        check("t4_jam_set", bus.jam, 1);
        check("t4_coin_dropped", bus.coin_drv, 0);
        check("t4_busy_jam", bus.busy, 1);
        goto(e + 20);
        bus.jam_clr = 1'b1;
        hold = 1'b0;
        @(negedge clk);
        bus.jam_clr = 1'b0;
        check("t4_jam_cleared", bus.jam, 0);
        check("t4_coin_retry", bus.coin_drv, 1);
        goto(e + 23);
        check("t4_busy_done", bus.busy, 0);
        goto(e + 26);
`endif

        // reset mid-COIN with two events queued
        hold = 1'b1;
        e = cyc + 1;
        expect_pulse(2, e + 1, 4);
        for (int i = 0; i < 3; i++) begin
            bus.out = t6_ev[i][2];
            bus.change = t6_ev[i][1:0];
            @(negedge clk);
        end
        bus.out = 1'b0;
        bus.change = 2'b00;
        goto(e + 4);
        check("t6_coin_before_reset", bus.coin_drv, 1);
        check("t6_busy_before_reset", bus.busy, 1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("t6_reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        hold = 1'b0;
        goto(cyc + 20);
        check("t6_busy_after", bus.busy, 0);
        check("t6_state_after", bus.state_dbg, 0);

        check("exp_queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
